arqt_button_ctrl: RTL and testbench
===================================

ARQT_BUTTON_CTRL -- requirements
Module: arqt_button_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: number of push-button inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a new level; legal range 2 to 2^20.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port address, input, 2: Avalon-MM slave word address.
REQ-006 Port chipselect, input, 1: slave select; qualifies writes.
REQ-007 Port write_n, input, 1: active-low write strobe.
REQ-008 Port writedata, input, 32: write data.
REQ-009 Port readdata, output, 32: registered read data.
REQ-010 Port in_port, input, WIDTH: raw buttons, active-low (1 = released), asynchronous to clk.
REQ-011 Port irq, output, 1: level interrupt request, active-high.

Function
REQ-012 Each in_port bit SHALL pass through a 2-flop synchronizer; sync output is "raw".
REQ-013 Each bit SHALL have a debounced "stable" level and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-014 While raw equals stable, the counter SHALL hold at 0.
REQ-015 While raw differs from stable, the counter SHALL increment by 1 per cycle.
REQ-016 When raw differs and the counter equals DEBOUNCE_CYCLES-1, stable SHALL take raw and the counter SHALL return to 0 in the same cycle.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL restart the counter at 0 and leave stable unchanged; the counter never wraps.
REQ-018 A press event SHALL be flagged for bit i in the cycle stable[i] changes 1->0; a release (0->1) SHALL NOT flag.
REQ-019 Register map (word address): 0 = stable (RO); 1 = irq mask (RW, WIDTH bits); 2 = raw (RO); 3 = edge capture (write-1-to-clear).
REQ-020 A write occurs when chipselect=1 and write_n=0; writes to addresses 0 and 2 SHALL be ignored.
REQ-021 Edge capture bit i SHALL set on a press event for bit i and stay set until cleared by writing 1 to bit i at address 3.
REQ-022 Simultaneous press event and clear on the same bit: set SHALL win.
REQ-023 readdata SHALL be updated every cycle from the address-selected register, read latency 1, bits 31:WIDTH zero.
REQ-024 irq SHALL be registered and equal OR over (edge capture AND mask), one cycle after either changes.
REQ-025 Writing mask with pending edges SHALL assert irq the following cycle; clearing mask SHALL deassert it the following cycle.

Reset
REQ-026 On reset_n=0: synchronizer flops and stable = all 1s; counters = 0; mask = 0; edge capture = 0; readdata = 0; irq = 0.
REQ-027 Reset mid-debounce SHALL discard the count; no press event SHALL be generated by reset release.

Structure
REQ-028 Package arqt_button_pkg SHALL hold register address constants (ADDR_DATA=0, ADDR_MASK=1, ADDR_RAW=2, ADDR_EDGE=3) and default WIDTH.
REQ-029 Sub-module arqt_debounce (single bit: synchronizer, counter, stable, press pulse) SHALL be instantiated WIDTH times.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4)
REQ-030 Reset, no stimulus -> reads addr 0 = 0xF, addr 1 = 0, addr 3 = 0; irq = 0.
REQ-031 in_port[0] low 3 cycles then high -> addr 0 stays 0xF, addr 3 stays 0.
REQ-032 in_port[0] held low -> addr 2 = 0xE after 2 cycles, addr 0 = 0xE and addr 3 = 0x1 after 6 cycles; release sets no edge.
REQ-033 Mask=0x1, press bit 0 -> irq high; write 0x1 to addr 3 -> irq low next cycle, addr 3 reads 0.
REQ-034 Clear write to addr 3 in the press-event cycle of bit 1 -> bit 1 remains set.
REQ-035 reset_n pulsed low during a press debounce -> all registers at reset values, no edge after release with in_port=0xF.

Source files
------------

// File: rtl/arqt_button_pkg.sv
// rtl/arqt_button_pkg.sv - shared constants for the push-button controller
package arqt_button_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_RAW  = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/arqt_button_ctrl_if.sv
// rtl/arqt_button_ctrl_if.sv - Avalon-MM slave register bus for the button controller
interface arqt_button_ctrl_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/arqt_debounce.sv
// rtl/arqt_debounce.sv - single-bit synchronizer and debouncer with press pulse
module arqt_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_i,
   output logic raw_o,
   output logic stable_o,
   output logic press_o
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          raw_q;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          flip;

   // The counter only runs while raw disagrees with stable, so any agreeing
   // sample restarts the qualification window from zero.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      flip     = 1'b0;
      if (raw_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            flip     = 1'b1;
            stable_d = raw_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b1;
         raw_q    <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= in_i;
         raw_q    <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign raw_o    = raw_q;
   assign stable_o = stable_q;
   assign press_o  = flip & ~raw_q;

endmodule

// File: rtl/arqt_button_ctrl.sv
// rtl/arqt_button_ctrl.sv - debounced push-button register block with masked press interrupt
module arqt_button_ctrl
   import arqt_button_pkg::*;
#(
   parameter int WIDTH           = DEFAULT_WIDTH,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   arqt_button_ctrl_if.slave    bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   logic [WIDTH-1:0] raw, stable, press;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] clr;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic             wr_en;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      arqt_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk      (clk),
         .reset_n  (reset_n),
         .in_i     (in_port[i]),
         .raw_o    (raw[i]),
         .stable_o (stable[i]),
         .press_o  (press[i])
      );
   end

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign unused_wdata = ^bus.writedata;

   // Press is OR-ed in after the clear so a same-cycle event survives.
   always_comb begin
      mask_d = mask_q;
      clr    = '0;
      if (wr_en && bus.address == ADDR_MASK) mask_d = bus.writedata[WIDTH-1:0];
      if (wr_en && bus.address == ADDR_EDGE) clr    = bus.writedata[WIDTH-1:0];
      edge_d = (edge_q & ~clr) | press;
      irq_d  = |(edge_q & mask_q);
   end

   always_comb begin
      readdata_d = '0;
      case (bus.address)
         ADDR_DATA: readdata_d = 32'(stable);
         ADDR_MASK: readdata_d = 32'(mask_q);
         ADDR_RAW:  readdata_d = 32'(raw);
         ADDR_EDGE: readdata_d = 32'(edge_q);
         default:   readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q     <= '0;
         edge_q     <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_arqt_button_ctrl.sv
// tb/tb_arqt_button_ctrl.sv - self-checking bench for arqt_button_ctrl
module tb_arqt_button_ctrl;
   import arqt_button_pkg::*;

   localparam int W  = 4;
   localparam int DC = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] in_port = '1;
   logic         irq;
   int           n_checks = 0;
   int           n_fail = 0;

   arqt_button_ctrl_if bus ();

   arqt_button_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .in_port (in_port),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // Reference: a button is accepted once its last DC synchronized samples
   // all disagree with the accepted level.
   logic [W-1:0] m_sync1, m_raw, m_stable, m_mask, m_edge;
   logic [31:0]  m_rd;
   logic         m_irq;
   logic [W-1:0] m_hist[$];
   logic [W-1:0] m_press, m_clr, m_nstable;
   logic [31:0]  m_nrd;
   logic         m_wr;

   function automatic bit settled(int b);
      if (m_hist.size() < DC) return 1'b0;
      for (int k = m_hist.size() - DC; k < m_hist.size(); k++)
         if (m_hist[k][b] == m_stable[b]) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_sync1 = '1; m_raw = '1; m_stable = '1;
         m_mask = '0; m_edge = '0; m_rd = '0; m_irq = 1'b0;
         m_hist.delete();
      end else begin
         m_wr = bus.chipselect && !bus.write_n;
         m_hist.push_back(m_raw);
         if (m_hist.size() > DC) void'(m_hist.pop_front());
         m_press = '0;
         m_nstable = m_stable;
         for (int b = 0; b < W; b++)
            if (settled(b)) begin
               m_nstable[b] = m_raw[b];
               if (m_raw[b] == 1'b0) m_press[b] = 1'b1;
            end
         case (bus.address)
            ADDR_DATA: m_nrd = {28'd0, m_stable};
            ADDR_MASK: m_nrd = {28'd0, m_mask};
            ADDR_RAW:  m_nrd = {28'd0, m_raw};
            default:   m_nrd = {28'd0, m_edge};
         endcase
         m_irq = |(m_edge & m_mask);
         m_clr = (m_wr && bus.address == ADDR_EDGE) ? bus.writedata[W-1:0] : '0;
         m_edge = (m_edge & ~m_clr) | m_press;
         if (m_wr && bus.address == ADDR_MASK) m_mask = bus.writedata[W-1:0];
         m_rd = m_nrd;
         m_stable = m_nstable;
         m_raw = m_sync1;
         m_sync1 = in_port;
      end
   end

   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.address = a;
      @(negedge clk);
      d = bus.readdata;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset_n = 1'b0;
      step(2);
      n_checks++;
      if (bus.readdata !== 32'h0 || irq !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs: got rd=%0h irq=%0b expected rd=0 irq=0", bus.readdata, irq);
      end
      reset_n = 1'b1;
      step(1);
      rd(ADDR_DATA, d);
      n_checks++;
      if (d !== 32'hF) begin n_fail++; $display("FAIL reset_stable: got %0h expected f", d); end
      rd(ADDR_MASK, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %0h expected 0", d); end
      rd(ADDR_EDGE, d);
      n_checks++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         n_fail++; $display("FAIL reset_edge: got %0h irq=%0b expected 0 irq=0", d, irq);
      end
   endtask

   task automatic test_glitch();
      logic [31:0] d;
      in_port = 4'hE;
      step(3);
      in_port = 4'hF;
      step(8);
      rd(ADDR_DATA, d);
      n_checks++;
      if (d !== 32'hF) begin n_fail++; $display("FAIL glitch_stable: got %0h expected f", d); end
      rd(ADDR_EDGE, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_edge: got %0h expected 0", d); end
   endtask

   task automatic test_press();
      logic [31:0] d;
      bus.address = ADDR_RAW;
      in_port = 4'hE;
      step(3);
      n_checks++;
      if (bus.readdata !== 32'hE) begin n_fail++; $display("FAIL press_raw: got %0h expected e", bus.readdata); end
      bus.address = ADDR_DATA;
      step(3);
      n_checks++;
      if (bus.readdata !== 32'hF) begin n_fail++; $display("FAIL press_early: got %0h expected f", bus.readdata); end
      step(1);
      n_checks++;
      if (bus.readdata !== 32'hE) begin n_fail++; $display("FAIL press_stable: got %0h expected e", bus.readdata); end
      rd(ADDR_EDGE, d);
      n_checks++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL press_edge: got %0h expected 1", d); end
      in_port = 4'hF;
      step(10);
      rd(ADDR_EDGE, d);
      n_checks++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL release_edge: got %0h expected 1", d); end
      wr(ADDR_EDGE, 32'hF);
      step(1);
   endtask

   task automatic test_irq();
      logic [31:0] d;
      wr(ADDR_MASK, 32'h1);
      in_port = 4'hE;
      step(8);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_press: got %0b expected 1", irq); end
      wr(ADDR_EDGE, 32'h1);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_clear_lat: got %0b expected 1", irq); end
      step(1);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %0b expected 0", irq); end
      rd(ADDR_EDGE, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL irq_edge_clr: got %0h expected 0", d); end
      in_port = 4'hF;
      wr(ADDR_MASK, 32'h0);
      step(8);
      in_port = 4'hE;
      step(8);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %0b expected 0", irq); end
      wr(ADDR_MASK, 32'h1);
      step(1);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmask: got %0b expected 1", irq); end
      wr(ADDR_MASK, 32'h0);
      step(1);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_remask: got %0b expected 0", irq); end
      in_port = 4'hF;
      step(8);
      wr(ADDR_EDGE, 32'hF);
   endtask

   task automatic test_clear_race();
      logic [31:0] d;
      step(4);
      in_port = 4'hD;
      step(5);
      wr(ADDR_EDGE, 32'h2);
      rd(ADDR_EDGE, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL race_set_wins: got %0h expected 2", d); end
      wr(ADDR_EDGE, 32'h2);
      rd(ADDR_EDGE, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL race_later_clear: got %0h expected 0", d); end
      in_port = 4'hF;
      step(8);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      wr(ADDR_MASK, 32'hF);
      in_port = 4'hB;
      step(4);
      reset_n = 1'b0;
      step(1);
      n_checks++;
      if (bus.readdata !== 32'h0 || irq !== 1'b0) begin
         n_fail++; $display("FAIL midrst_outputs: got rd=%0h irq=%0b expected rd=0 irq=0", bus.readdata, irq);
      end
      in_port = 4'hF;
      reset_n = 1'b1;
      step(10);
      rd(ADDR_DATA, d);
      n_checks++;
      if (d !== 32'hF) begin n_fail++; $display("FAIL midrst_stable: got %0h expected f", d); end
      rd(ADDR_MASK, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_mask: got %0h expected 0", d); end
      rd(ADDR_EDGE, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_edge: got %0h expected 0", d); end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < W; b++)
            if ($urandom_range(5) == 0) in_port[b] = ~in_port[b];
         bus.address    = 2'($urandom_range(3));
         bus.chipselect = ($urandom_range(3) == 0);
         bus.write_n    = ($urandom_range(1) == 0);
         bus.writedata  = $urandom;
         @(negedge clk);
         n_checks++;
         if (bus.readdata !== m_rd || irq !== m_irq) begin
            n_fail++; errs++;
            if (errs <= 10)
               $display("FAIL random_cycle%0d: got rd=%0h irq=%0b expected rd=%0h irq=%0b",
                        c, bus.readdata, irq, m_rd, m_irq);
         end
      end
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   initial begin
      bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
      @(negedge clk);
      test_reset();
      test_glitch();
      test_press();
      test_irq();
      test_clear_race();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
